// File: rtl/shift_reg_xfer.sv
// shift_reg_xfer: universal WIDTH-bit shift register with a frame sequencer.
// A start command latches direction and mode, then exactly WIDTH shifts are
// performed (stalled by en=0), followed by a one-cycle done state.
module shift_reg_xfer #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic             dir,
    input  logic             rot,
    input  logic             en,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    cnt
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;
    logic             rot_q, rot_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    cnt_inc;
    logic             in_bit;

    assign cnt_inc = cnt_q + CW'(1);

    // Outgoing bit; in rotate mode it is also the bit that re-enters.
    assign sout   = dir_q ? data_q[0] : data_q[WIDTH-1];
    assign in_bit = rot_q ? sout : sin;

    assign q    = data_q;
    assign cnt  = cnt_q;
    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);

    // Next-state: command decode in IDLE/DONE, shift sequencing in SHIFT.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (load) begin
                    data_d  = d;
                    state_d = StIdle;
                end else if (start) begin
                    dir_d   = dir;
                    rot_d   = rot;
                    cnt_d   = '0;
                    state_d = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                // Commands are ignored here; only reset can abort a frame.
                if (en) begin
                    data_d = dir_q ? {in_bit, data_q[WIDTH-1:1]}
                                   : {data_q[WIDTH-2:0], in_bit};
                    cnt_d  = cnt_inc;
                    if (cnt_inc == CW'(WIDTH)) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            data_q  <= '0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_shift_reg_xfer.sv
// tb_shift_reg_xfer: scoreboard bench. Frames push their expected serial
// stream and final word; a negedge monitor pops them as the DUT shifts/finishes.
module tb_shift_reg_xfer;

    localparam int unsigned W  = 12;
    localparam int unsigned CW = $clog2(W + 1);

    logic          clk;
    logic          reset;
    logic          load;
    logic [W-1:0]  d;
    logic          start;
    logic          dir;
    logic          rot;
    logic          en;
    logic          sin;
    logic [W-1:0]  q;
    logic          sout;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic         sout_sb[$];
    logic [W-1:0] final_sb[$];
    logic [W-1:0] model_q;
    logic         mon_bit;
    logic [W-1:0] mon_word;

    shift_reg_xfer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .d     (d),
        .start (start),
        .dir   (dir),
        .rot   (rot),
        .en    (en),
        .sin   (sin),
        .q     (q),
        .sout  (sout),
        .busy  (busy),
        .done  (done),
        .cnt   (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every shift edge must match the next expected serial bit, every
    // done cycle must present the next expected final word with cnt == W.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (busy && en) begin
                if (sout_sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_shift: got unexpected shift, expected none");
                end else begin
                    mon_bit = sout_sb.pop_front();
                    check("sout", 32'(sout), 32'(mon_bit));
                end
            end
            if (done) begin
                if (final_sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_done: got unexpected done, expected none");
                end else begin
                    mon_word = final_sb.pop_front();
                    check("final_q", 32'(q), 32'(mon_word));
                    check("final_cnt", 32'(cnt), W);
                end
            end
        end
    end

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic do_load(input logic [W-1:0] v);
        d     = v;
        load  = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        load    = 1'b0;
        model_q = v;
        check("load_q", 32'(q), 32'(v));
        check("load_busy", 32'(busy), 0);
    endtask

    // One frame. The model: the old word streams out in shift order, and the
    // new word is either the old word (rotate) or the serial input word s, whose
    // bits are fed MSB-first for left shifts and LSB-first for right shifts.
    task automatic run_frame(input logic fdir, input logic frot, input logic [W-1:0] s,
                             input int stall_at, input int stall_len, input bit rand_stall,
                             input int abort_at);
        int  shifts  = 0;
        int  stalled = 0;
        bit  do_en;
        load  = 1'b0;
        start = 1'b1;
        dir   = fdir;
        rot   = frot;
        en    = 1'($urandom);
        sin   = 1'($urandom);
        for (int i = 0; i < int'(W); i++) begin
            sout_sb.push_back(fdir ? model_q[i] : model_q[W-1-i]);
        end
        final_sb.push_back(frot ? model_q : s);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_cnt", 32'(cnt), 0);
        while (shifts < int'(W)) begin
            if (shifts == abort_at) begin
                en = 1'b0;
                #3;
                reset = 1'b0;
                #1;
                check("abort_q", 32'(q), 0);
                check("abort_busy", 32'(busy), 0);
                check("abort_cnt", 32'(cnt), 0);
                check("abort_sout", 32'(sout), 0);
                sout_sb.delete();
                final_sb.delete();
                model_q = '0;
                repeat (2) @(posedge clk);
                #1;
                check("abort_done", 32'(done), 0);
                reset = 1'b1;
                return;
            end
            if (shifts == stall_at && stalled < stall_len) do_en = 1'b0;
            else if (rand_stall) do_en = ($urandom_range(0, 3) != 0);
            else do_en = 1'b1;
            if (!do_en) stalled++;
            en    = do_en;
            sin   = fdir ? s[shifts] : s[W-1-shifts];
            // Commands during a transfer must be ignored.
            load  = 1'($urandom);
            start = 1'($urandom);
            dir   = 1'($urandom);
            rot   = 1'($urandom);
            d     = W'($urandom);
            @(posedge clk);
            #1;
            if (do_en) shifts++;
            check("shift_cnt", 32'(cnt), 32'(shifts));
            if (shifts < int'(W)) check("shift_busy", 32'(busy), 1);
        end
        en    = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        check("end_done", 32'(done), 1);
        check("end_busy", 32'(busy), 0);
        if (stall_len > 0 && !rand_stall) check("stall_count", 32'(stalled), 32'(stall_len));
        model_q = frot ? model_q : s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int choice;
        reset   = 1'b0;
        load    = 1'b0;
        start   = 1'b0;
        d       = '0;
        dir     = 1'b0;
        rot     = 1'b0;
        en      = 1'b0;
        sin     = 1'b0;
        model_q = '0;

        // Reset held with inputs toggling.
        for (int i = 0; i < 4; i++) begin
            load  = 1'($urandom);
            start = 1'($urandom);
            d     = W'($urandom);
            dir   = 1'($urandom);
            rot   = 1'($urandom);
            en    = 1'($urandom);
            sin   = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst_q", 32'(q), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_done", 32'(done), 0);
            check("rst_cnt", 32'(cnt), 0);
            check("rst_sout", 32'(sout), 0);
        end
        load  = 1'b0;
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_load(12'hA5C);

        // Left serial transfer.
        run_frame(1'b0, 1'b0, 12'h3F0, -1, 0, 1'b0, -1);
        check("left_q", 32'(q), 32'h3F0);

        // Right rotate.
        do_load(12'h801);
        run_frame(1'b1, 1'b1, W'($urandom), -1, 0, 1'b0, -1);

        // Stall of 3 cycles mid-frame with commands pulsed.
        run_frame(1'b0, 1'b1, W'($urandom), 6, 3, 1'b0, -1);

        // Load and start together in IDLE: load wins.
        @(posedge clk);
        #1;
        d     = 12'h5A3;
        load  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        model_q = 12'h5A3;
        check("prio_q", 32'(q), 32'h5A3);
        check("prio_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        check("prio_busy2", 32'(busy), 0);
        check("idle_cnt_hold", 32'(cnt), W);

        // Chained frames: second start issued in the done cycle.
        run_frame(1'b1, 1'b0, W'($urandom), -1, 0, 1'b0, -1);
        run_frame(1'b0, 1'b0, W'($urandom), -1, 0, 1'b0, -1);

        // Reset mid-transfer at cnt = 5, then a full frame.
        do_load(W'($urandom));
        run_frame(1'b0, 1'b0, W'($urandom), -1, 0, 1'b0, 5);
        run_frame(1'b1, 1'b0, W'($urandom), -1, 0, 1'b0, -1);

        // Randomised frames with random follow-up actions.
        for (int f = 0; f < 20; f++) begin
            run_frame(1'($urandom), 1'($urandom), W'($urandom), -1, 0, 1'b1, -1);
            choice = $urandom_range(0, 2);
            if (choice == 1) begin
                do_load(W'($urandom));
            end else if (choice == 2) begin
                en  = 1'($urandom);
                sin = 1'($urandom);
                @(posedge clk);
                #1;
                check("idle_done", 32'(done), 0);
                check("idle_busy", 32'(busy), 0);
                check("idle_cnt", 32'(cnt), W);
                check("idle_q", 32'(q), 32'(model_q));
            end
        end

        @(posedge clk);
        #1;
        check("sb_sout_left", 32'(sout_sb.size()), 0);
        check("sb_final_left", 32'(final_sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
